exponent_bit_streamer: RTL
==========================

Name: exponent_bit_streamer

Overview:
- Buffers a full exponent, such as the 2048-bit plaintext or randomness exponent, that arrives as REGISTER_SIZE-bit blocks.
- Presents the exponent one bit at a time on n_bit_out to the Montgomery square-and-multiply accumulator.
- Advances one bit per consume pulse from the accumulator.
- Double-buffered: the next exponent can be loaded while the current one is streamed, so back-to-back exponentiations have no gap.

Parameters:
REGISTER_SIZE, 32, width of one input block
BITS_IN_EXP, 2048, exponent width in bits; must be a multiple of REGISTER_SIZE
(derived) BLOCKS_PER_EXP = BITS_IN_EXP/REGISTER_SIZE; BIT_IDX_W = $clog2(BITS_IN_EXP)

Ports:
clk_in  input  1  system clock; all state updates on its rising edge
rst_in  input  1  asynchronous, active-low reset
block_valid_in  input  1  block_in holds a valid exponent block
block_in  input  REGISTER_SIZE  exponent block; block 0 holds exponent bits [REGISTER_SIZE-1:0]
block_ready_out  output  1  shadow buffer can accept a block
consumed_n_in  input  1  single-cycle pulse: accumulator used the current bit
n_bit_out  output  1  current exponent bit; 0 when exp_valid_out is low
exp_valid_out  output  1  active buffer holds an exponent being streamed
last_bit_out  output  1  current bit is the final bit of the exponent
exp_done_out  output  1  one-cycle pulse when the final bit is consumed
bit_idx_out  output  BIT_IDX_W  index of the current bit (debug / verification)

Behaviour:
- Reset (rst_in low, asynchronous) clears the following immediately:
  - shadow buffer, fill count and shadow_full;
  - active buffer and bit_idx;
  - stream state to IDLE.
- Output values in reset: block_ready_out=1; n_bit_out, exp_valid_out, last_bit_out and exp_done_out all 0; bit_idx_out=0.
- Reset mid-load or mid-stream discards all data. There is no partial recovery.
- Load side, state FILLING / FULL:
  - block_ready_out = !shadow_full.
  - A block is accepted when block_valid_in && block_ready_out are both high at an edge.
  - Each accepted block is written to slot fill_cnt, then fill_cnt increments.
  - On acceptance of slot BLOCKS_PER_EXP-1, shadow_full is set. block_ready_out is low from the next cycle.
  - block_valid_in while shadow_full is high is ignored, and the data is not consumed.
- Swap (shadow to active) happens at an edge when shadow_full is high and either:
  - the stream state is IDLE; or
  - the stream is STREAMING with last_bit_out && consumed_n_in high.
- At a swap:
  - active <= shadow, bit_idx <= 0, stream state <= STREAMING;
  - shadow_full <= 0 and fill_cnt <= 0, so block_ready_out=1 in the next cycle.
- Latency: the final block is accepted at edge E. With the stream IDLE, the swap occurs at edge E+1 and exp_valid_out is high after E+1. A block cannot be accepted and swapped on the same edge.
- Stream side, state IDLE / STREAMING:
  - n_bit_out = active[bit_idx] while STREAMING. It is a registered source, so there is no combinational path from consumed_n_in.
  - consumed_n_in while STREAMING and not on the last bit: bit_idx increments and the new bit is visible in the next cycle.
  - consumed_n_in on the last bit (bit_idx=BITS_IN_EXP-1): exp_done_out pulses in the next cycle. Then one of:
    - swap pending: STREAMING continues with bit 0 of the new exponent and exp_valid_out stays high;
    - no swap pending: the state goes to IDLE and exp_valid_out falls.
  - consumed_n_in while IDLE is ignored.
- last_bit_out = STREAMING && bit_idx==BITS_IN_EXP-1.
- Simultaneous events:
  - a block acceptance and a consume in the same cycle are independent and both take effect;
  - a final-bit consume together with a swap produces exp_done_out and a zero-gap restart.

Optional Feature:
Macro EXP_BIT_MSB_FIRST_EN.
- Defined: bits are streamed MSB first. The bit presented at step i is active[BITS_IN_EXP-1-i]. bit_idx_out still counts steps 0..BITS_IN_EXP-1.
- Undefined (default): bits are streamed LSB first, matching the accumulator's square-and-multiply order, which squares the base upward from bit 0.
- The load order, handshakes and timing are identical in both builds.

Test Plan:
- Use REGISTER_SIZE=32, BITS_IN_EXP=64 for all scenarios below.
- Reset: hold rst_in low with random inputs -> outputs at their reset values, block_ready_out=1, exp_valid_out=0; release rst_in -> no output change until a block is loaded.
- Single exponent, LSB first: load blocks 0x0000_0005 then 0x8000_0000, then pulse consumed_n_in 64 times with random gaps -> n_bit_out sequence 1,0,1,0…0,1. last_bit_out is high only at idx 63. exp_done_out pulses once, then exp_valid_out=0.
- Back-to-back: load exponent A, then load exponent B while A streams. After B's two blocks, block_ready_out=0 -> the final consume of A is followed next cycle by exp_valid_out=1, bit_idx_out=0 and B's bit 0, with no IDLE cycle.
- Backpressure: shadow full with A streaming; drive block_valid_in=1 with 0xDEAD_BEEF -> the block is not accepted and B in the shadow is unchanged. Once A finishes, the swap occurs and block_ready_out returns to 1 the next cycle.
- Consume while idle, then reset mid-stream: pulse consumed_n_in with no exponent loaded -> bit_idx_out stays 0. Load an exponent, consume 10 bits, then assert rst_in low -> everything is cleared immediately. After release, the next load streams from bit 0.
- MSB first, built with EXP_BIT_MSB_FIRST_EN: load 0x0000_0005, 0x8000_0000 -> the first n_bit_out is 1 (bit 63), then 0,0,…; the last three steps are 1,0,1.

Source files
------------

// File: rtl/exponent_bit_streamer.sv
// Exponent bit streamer: double-buffered exponent store feeding a square-and-multiply accumulator one bit per consume pulse.
// Latency: final block accepted at edge E swaps into the active buffer at E+1 when idle; a consume advances the bit at the next edge.
// Backpressure: block_ready_out drops while the shadow buffer holds a complete exponent awaiting swap; consumes while idle are ignored.
// Optional build macro EXP_BIT_MSB_FIRST_EN: stream MSB first instead of the default LSB-first order.
module exponent_bit_streamer #(
    parameter  int REGISTER_SIZE  = 32,
    parameter  int BITS_IN_EXP    = 2048,
    localparam int BLOCKS_PER_EXP = BITS_IN_EXP / REGISTER_SIZE,
    localparam int BIT_IDX_W      = $clog2(BITS_IN_EXP)
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     block_valid_in,
    input  logic [REGISTER_SIZE-1:0] block_in,
    output logic                     block_ready_out,
    input  logic                     consumed_n_in,
    output logic                     n_bit_out,
    output logic                     exp_valid_out,
    output logic                     last_bit_out,
    output logic                     exp_done_out,
    output logic [BIT_IDX_W-1:0]     bit_idx_out
);

    // Fill counter needs at least one bit even for a single-block exponent.
    localparam int FILL_W = (BLOCKS_PER_EXP > 1) ? $clog2(BLOCKS_PER_EXP) : 1;

    localparam logic [FILL_W-1:0]    LAST_BLK = FILL_W'(BLOCKS_PER_EXP - 1);
    localparam logic [BIT_IDX_W-1:0] LAST_IDX = BIT_IDX_W'(BITS_IN_EXP - 1);

    // Stream state encoding.
    localparam logic [0:0] ST_IDLE      = 1'b0;
    localparam logic [0:0] ST_STREAMING = 1'b1;

    // Load side: shadow buffer held as blocks so each write is a whole-slot update.
    logic [REGISTER_SIZE-1:0] shadow_q [BLOCKS_PER_EXP];
    logic [REGISTER_SIZE-1:0] shadow_d [BLOCKS_PER_EXP];
    logic [FILL_W-1:0]        fill_cnt_q;
    logic [FILL_W-1:0]        fill_cnt_d;
    logic                     shadow_full_q;
    logic                     shadow_full_d;

    // Stream side: active exponent, step counter and state.
    logic [BITS_IN_EXP-1:0]   active_q;
    logic [BITS_IN_EXP-1:0]   active_d;
    logic [BIT_IDX_W-1:0]     bit_idx_q;
    logic [BIT_IDX_W-1:0]     bit_idx_d;
    logic [0:0]               state_q;
    logic [0:0]               state_d;
    logic                     exp_done_q;
    logic                     exp_done_d;

    // Decoded events for the current cycle.
    logic                     streaming;
    logic                     on_last;
    logic                     accept;
    logic                     last_consume;
    logic                     swap;
    logic [BITS_IN_EXP-1:0]   shadow_flat;
    logic [BIT_IDX_W-1:0]     sel_idx;

    // Event decode: acceptance and swap are mutually exclusive because accept needs a non-full shadow.
    always_comb begin
        streaming    = (state_q == ST_STREAMING);
        on_last      = streaming && (bit_idx_q == LAST_IDX);
        accept       = block_valid_in && !shadow_full_q;
        last_consume = on_last && consumed_n_in;
        swap         = shadow_full_q && (!streaming || last_consume);
    end

    // Flatten the shadow blocks; block 0 supplies the least significant bits.
    always_comb begin
        shadow_flat = '0;
        for (int b = 0; b < BLOCKS_PER_EXP; b++) begin
            shadow_flat[b*REGISTER_SIZE +: REGISTER_SIZE] = shadow_q[b];
        end
    end

    // Load-side next state: fill slots in order, mark full on the last slot, empty on swap.
    always_comb begin
        shadow_d      = shadow_q;
        fill_cnt_d    = fill_cnt_q;
        shadow_full_d = shadow_full_q;
        if (accept) begin
            shadow_d[fill_cnt_q] = block_in;
            if (fill_cnt_q == LAST_BLK) begin
                shadow_full_d = 1'b1;
                fill_cnt_d    = '0;
            end else begin
                fill_cnt_d = fill_cnt_q + FILL_W'(1);
            end
        end
        if (swap) begin
            shadow_full_d = 1'b0;
            fill_cnt_d    = '0;
        end
    end

    // Stream-side next state: swap wins over a plain final-bit retire so the restart has no gap.
    always_comb begin
        active_d   = active_q;
        bit_idx_d  = bit_idx_q;
        state_d    = state_q;
        exp_done_d = last_consume;
        if (swap) begin
            active_d  = shadow_flat;
            bit_idx_d = '0;
            state_d   = ST_STREAMING;
        end else if (last_consume) begin
            bit_idx_d = '0;
            state_d   = ST_IDLE;
        end else if (streaming && consumed_n_in) begin
            bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
        end
    end

    // Load-side registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int b = 0; b < BLOCKS_PER_EXP; b++) begin
                shadow_q[b] <= '0;
            end
            fill_cnt_q    <= '0;
            shadow_full_q <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            fill_cnt_q    <= fill_cnt_d;
            shadow_full_q <= shadow_full_d;
        end
    end

    // Stream-side registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            active_q   <= '0;
            bit_idx_q  <= '0;
            state_q    <= ST_IDLE;
            exp_done_q <= 1'b0;
        end else begin
            active_q   <= active_d;
            bit_idx_q  <= bit_idx_d;
            state_q    <= state_d;
            exp_done_q <= exp_done_d;
        end
    end

`ifdef EXP_BIT_MSB_FIRST_EN
    // Step i presents the bit counted down from the top of the exponent.
    always_comb sel_idx = LAST_IDX - bit_idx_q;
`else
    // Step i presents bit i, the order the accumulator squares the base in.
    always_comb sel_idx = bit_idx_q;
`endif

    // Outputs are pure decodes of registers; consumed_n_in never reaches them combinationally.
    always_comb begin
        block_ready_out = !shadow_full_q;
        exp_valid_out   = streaming;
        n_bit_out       = streaming ? active_q[sel_idx] : 1'b0;
        last_bit_out    = on_last;
        exp_done_out    = exp_done_q;
        bit_idx_out     = bit_idx_q;
    end

endmodule
